interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: pushes return PC, fetches vector, pops on RTI.
// Ports: clk, rst (async high), int_req/rti_req/mem_busy requests, pc_in/sp_in
//   context, mem_* data-memory master, stall/flush/int_ack pipeline control,
//   pc_load/pc_out fetch redirect, sp_we/sp_out stack pointer update.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic        mem_busy,
  input  logic [31:0] pc_in,
  input  logic [15:0] sp_in,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        stall,
  output logic        flush,
  output logic        int_ack,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        sp_we,
  output logic [15:0] sp_out
);

  typedef enum logic [3:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    VEC_HI,
    VEC_LO,
    VEC_DONE,
    POP_LO,
    POP_HI,
    POP_DONE
  } state_t;

  localparam logic [15:0] VEC_ADDR_LO = VEC_ADDR + 16'd1;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [15:0] sp_q, sp_d;
  logic [31:0] pc_q, pc_d;

  logic [15:0] addr_c;
  logic [15:0] wdata_c;
  logic        we_c;
  logic        re_c;
  logic        stall_c;
  logic        flush_c;
  logic        ack_c;
  logic        load_c;
  logic [31:0] pc_out_c;
  logic        sp_we_c;
  logic [15:0] sp_out_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      ret_pc_q <= 32'h0;
      sp_q     <= 16'h0;
      pc_q     <= 32'h0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ret_pc_q <= ret_pc_d;
      sp_q     <= sp_d;
      pc_q     <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | int_req;
    ret_pc_d = ret_pc_q;
    sp_d     = sp_q;
    pc_d     = pc_q;
    addr_c   = 16'h0;
    wdata_c  = 16'h0;
    we_c     = 1'b0;
    re_c     = 1'b0;
    stall_c  = 1'b1;
    flush_c  = 1'b0;
    ack_c    = 1'b0;
    load_c   = 1'b0;
    pc_out_c = pc_q;
    sp_we_c  = 1'b0;
    sp_out_c = 16'h0;

    unique case (state_q)
      IDLE: begin
        stall_c = 1'b0;
        // RTI has priority; a coincident interrupt stays pending.
        if (rti_req && !mem_busy) begin
          state_d = POP_LO;
          sp_d    = sp_in;
          flush_c = 1'b1;
          stall_c = 1'b1;
        end else if ((pend_q || int_req) && !mem_busy) begin
          state_d  = PUSH_HI;
          ret_pc_d = pc_in;
          sp_d     = sp_in;
          pend_d   = 1'b0;
          ack_c    = 1'b1;
          flush_c  = 1'b1;
          stall_c  = 1'b1;
        end
      end
      PUSH_HI: begin
        we_c    = 1'b1;
        addr_c  = sp_q;
        wdata_c = ret_pc_q[31:16];
        sp_d    = sp_q - 16'd1;
        state_d = PUSH_LO;
      end
      PUSH_LO: begin
        we_c    = 1'b1;
        addr_c  = sp_q;
        wdata_c = ret_pc_q[15:0];
        sp_d    = sp_q - 16'd1;
        state_d = VEC_HI;
      end
      VEC_HI: begin
        re_c    = 1'b1;
        addr_c  = VEC_ADDR;
        state_d = VEC_LO;
      end
      VEC_LO: begin
        re_c        = 1'b1;
        addr_c      = VEC_ADDR_LO;
        pc_d[31:16] = mem_rdata;
        state_d     = VEC_DONE;
      end
      VEC_DONE: begin
        // Low half arrives this cycle; forward it so pc_out is whole with pc_load.
        pc_d[15:0] = mem_rdata;
        pc_out_c   = {pc_q[31:16], mem_rdata};
        load_c     = 1'b1;
        sp_we_c    = 1'b1;
        sp_out_c   = sp_q;
        state_d    = IDLE;
      end
      POP_LO: begin
        re_c    = 1'b1;
        addr_c  = sp_q + 16'd1;
        state_d = POP_HI;
      end
      POP_HI: begin
        re_c       = 1'b1;
        addr_c     = sp_q + 16'd2;
        pc_d[15:0] = mem_rdata;
        state_d    = POP_DONE;
      end
      POP_DONE: begin
        pc_d[31:16] = mem_rdata;
        pc_out_c    = {mem_rdata, pc_q[15:0]};
        load_c      = 1'b1;
        sp_we_c     = 1'b1;
        sp_out_c    = sp_q + 16'd2;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while rst is held, even though IDLE decodes inputs.
  assign mem_addr  = rst ? 16'h0 : addr_c;
  assign mem_wdata = rst ? 16'h0 : wdata_c;
  assign mem_we    = rst ? 1'b0 : we_c;
  assign mem_re    = rst ? 1'b0 : re_c;
  assign stall     = rst ? 1'b0 : stall_c;
  assign flush     = rst ? 1'b0 : flush_c;
  assign int_ack   = rst ? 1'b0 : ack_c;
  assign pc_load   = rst ? 1'b0 : load_c;
  assign pc_out    = rst ? 32'h0 : pc_out_c;
  assign sp_we     = rst ? 1'b0 : sp_we_c;
  assign sp_out    = rst ? 16'h0 : sp_out_c;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer with a behavioural data memory.
// Stimulus pushes expected writes/redirects; a negedge monitor pops and compares.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_req = 1'b0;
  logic        rti_req = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [15:0] sp_in = 16'h0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic        stall;
  logic        flush;
  logic        int_ack;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        sp_we;
  logic [15:0] sp_out;

  interrupt_sequencer #(.VEC_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .rti_req(rti_req),
    .mem_busy(mem_busy), .pc_in(pc_in), .sp_in(sp_in),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .stall(stall), .flush(flush),
    .int_ack(int_ack), .pc_load(pc_load), .pc_out(pc_out),
    .sp_we(sp_we), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_a = 16'h0;
  logic [15:0] tb_d = 16'h0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_a] <= tb_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] sp;
    int          lat;
  } ld_t;

  wr_t wrq[$];
  ld_t ldq[$];

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int last_ld_cyc = 0;
  int ack_gap = 0;
  int n_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (flush) acc_cyc = cyc;
      if (int_ack) begin
        ack_gap = cyc - last_ld_cyc;
        n_ack++;
      end
      if (mem_we) begin
        chk("wr_expected", 32'(wrq.size() > 0), 32'd1);
        if (wrq.size() > 0) begin
          wr_t w;
          w = wrq.pop_front();
          chk("wr_addr", {16'h0, mem_addr}, {16'h0, w.a});
          chk("wr_data", {16'h0, mem_wdata}, {16'h0, w.d});
        end
      end
      if (pc_load) begin
        last_ld_cyc = cyc;
        chk("ld_expected", 32'(ldq.size() > 0), 32'd1);
        if (ldq.size() > 0) begin
          ld_t l;
          l = ldq.pop_front();
          chk("pc_out", pc_out, l.pc);
          chk("sp_out", {16'h0, sp_out}, {16'h0, l.sp});
          chk("sp_we", {31'h0, sp_we}, 32'd1);
          chk("latency", 32'(cyc - acc_cyc), 32'(l.lat));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1;
    tb_a  = a;
    tb_d  = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (ldq.size() == 0 && wrq.size() == 0) break;
      step();
    end
    chk("drain_ld", ldq.size(), 0);
    chk("drain_wr", wrq.size(), 0);
    step();
  endtask

  task automatic quiet_chk(input string nm);
    chk({nm, "_stall"}, {31'h0, stall}, 32'd0);
    chk({nm, "_we"}, {31'h0, mem_we}, 32'd0);
    chk({nm, "_re"}, {31'h0, mem_re}, 32'd0);
    chk({nm, "_ack"}, {31'h0, int_ack}, 32'd0);
  endtask

  initial begin
    int_req = 1'b1;
    step();
    step();
    quiet_chk("rst");
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_sp_out", {16'h0, sp_out}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    int_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    poke(16'h0000, 16'h0000);
    poke(16'h0001, 16'h0100);

    // basic interrupt entry
    pc_in = 32'h0000_1234;
    sp_in = 16'h0FFF;
    wrq.push_back('{16'h0FFF, 16'h0000});
    wrq.push_back('{16'h0FFE, 16'h1234});
    ldq.push_back('{32'h0000_0100, 16'h0FFD, 5});
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    wait_done();
    chk("mem_0fff", {16'h0, mem[16'h0FFF]}, 32'h0000);
    chk("mem_0ffe", {16'h0, mem[16'h0FFE]}, 32'h1234);

    // basic return
    sp_in = 16'h0FFD;
    ldq.push_back('{32'h0000_1234, 16'h0FFF, 3});
    rti_req = 1'b1;
    step();
    rti_req = 1'b0;
    wait_done();

    // interrupt held off by memory stage
    poke(16'h0000, 16'hCAFE);
    poke(16'h0001, 16'h0042);
    mem_busy = 1'b1;
    pc_in = 32'hDEAD_BEEF;
    sp_in = 16'h2000;
    int_req = 1'b1;
    #1;
    quiet_chk("busy0");
    step();
    int_req = 1'b0;
    quiet_chk("busy1");
    step();
    quiet_chk("busy2");
    wrq.push_back('{16'h2000, 16'hDEAD});
    wrq.push_back('{16'h1FFF, 16'hBEEF});
    ldq.push_back('{32'hCAFE_0042, 16'h1FFE, 5});
    mem_busy = 1'b0;
    step();
    wait_done();

    // coincident RTI and interrupt: RTI first
    pc_in = 32'h0000_5555;
    sp_in = 16'h1FFE;
    ldq.push_back('{32'hDEAD_BEEF, 16'h2000, 3});
    rti_req = 1'b1;
    int_req = 1'b1;
    step();
    rti_req = 1'b0;
    int_req = 1'b0;
    sp_in = 16'h3000;
    wrq.push_back('{16'h3000, 16'h0000});
    wrq.push_back('{16'h2FFF, 16'h5555});
    ldq.push_back('{32'hCAFE_0042, 16'h2FFE, 5});
    wait_done();
    chk("ack_after_rti", 32'(ack_gap), 32'd1);

    // stack pointer wrap; push to 0 overwrites vector high word
    pc_in = 32'h89AB_CDEF;
    sp_in = 16'h0000;
    wrq.push_back('{16'h0000, 16'h89AB});
    wrq.push_back('{16'hFFFF, 16'hCDEF});
    ldq.push_back('{32'h89AB_0042, 16'hFFFE, 5});
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    wait_done();
    sp_in = 16'hFFFE;
    ldq.push_back('{32'h89AB_CDEF, 16'h0000, 3});
    rti_req = 1'b1;
    step();
    rti_req = 1'b0;
    wait_done();

    // reset in the middle of the vector fetch
    poke(16'h0000, 16'h0000);
    poke(16'h0001, 16'h0300);
    pc_in = 32'h1111_2222;
    sp_in = 16'h4000;
    wrq.push_back('{16'h4000, 16'h1111});
    wrq.push_back('{16'h3FFF, 16'h2222});
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    step();
    step();
    step();
    chk("vec_lo_re", {31'h0, mem_re}, 32'd1);
    chk("vec_lo_addr", {16'h0, mem_addr}, 32'h0001);
    rst = 1'b1;
    #1;
    quiet_chk("midrst");
    chk("midrst_addr", {16'h0, mem_addr}, 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_load", {31'h0, pc_load}, 32'd0);
    chk("midrst_sp_we", {31'h0, sp_we}, 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    step();
    chk("post_rst_wr", wrq.size(), 0);
    wrq.push_back('{16'h4000, 16'h1111});
    wrq.push_back('{16'h3FFF, 16'h2222});
    ldq.push_back('{32'h0000_0300, 16'h3FFE, 5});
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    wait_done();
    chk("ack_count", 32'(n_ack), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
